// File: rtl/demux1t4_tdm.sv
// demux1t4_tdm
// Receive-side 1:4 time-division demultiplexer. A single TDM stream whose
// transmitter steps through slots 0..3, holding each slot for SLOT_HOLD
// cycles, is split back into four registered lanes. A sync marker aligns
// the receiver to slot 0 / hold 0, and every complete frame is presented
// on O0..O3 together with a one-cycle valid pulse.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   en        advance enable; 0 freezes position, shadows and outputs
//   sync      frame marker; the current cycle is slot 0, hold 0
//   I0        TDM data stream (WIDTH bits)
//   O0..O3    recovered lanes, updated together once per frame
//   S         slot being received in the current cycle
//   valid     one-cycle pulse when O0..O3 hold a new complete frame
//   sync_err  one-cycle pulse when sync arrived off a frame boundary

module demux1t4_tdm #(
    parameter int WIDTH     = 1,
    parameter int SLOT_HOLD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic [WIDTH-1:0] I0,
    output logic [WIDTH-1:0] O0,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [WIDTH-1:0] O3,
    output logic [1:0]       S,
    output logic             valid,
    output logic             sync_err
);

    localparam int HW = (SLOT_HOLD > 1) ? $clog2(SLOT_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(SLOT_HOLD - 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_t;

    lock_t            state, state_nxt;
    logic [HW-1:0]    hold, hold_nxt, hold_eff;
    logic [1:0]       s_nxt, slot_eff;
    logic [WIDTH-1:0] sh0, sh1, sh2;
    logic [WIDTH-1:0] sh0_nxt, sh1_nxt, sh2_nxt;
    logic [WIDTH-1:0] o0_nxt, o1_nxt, o2_nxt, o3_nxt;
    logic             valid_nxt, err_nxt;
    logic             advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= UNLOCKED;
            hold     <= '0;
            S        <= 2'd0;
            sh0      <= '0;
            sh1      <= '0;
            sh2      <= '0;
            O0       <= '0;
            O1       <= '0;
            O2       <= '0;
            O3       <= '0;
            valid    <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold     <= hold_nxt;
            S        <= s_nxt;
            sh0      <= sh0_nxt;
            sh1      <= sh1_nxt;
            sh2      <= sh2_nxt;
            O0       <= o0_nxt;
            O1       <= o1_nxt;
            O2       <= o2_nxt;
            O3       <= o3_nxt;
            valid    <= valid_nxt;
            sync_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        s_nxt     = S;
        sh0_nxt   = sh0;
        sh1_nxt   = sh1;
        sh2_nxt   = sh2;
        o0_nxt    = O0;
        o1_nxt    = O1;
        o2_nxt    = O2;
        o3_nxt    = O3;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        slot_eff  = S;
        hold_eff  = hold;
        advance   = 1'b0;

        // sync overrides the tracked position for this cycle; an off-boundary
        // sync while locked throws away the partial frame in the shadows.
        if (en) begin
            if (sync) begin
                slot_eff  = 2'd0;
                hold_eff  = '0;
                state_nxt = LOCKED;
                if (state == LOCKED && (S != 2'd0 || hold != '0)) begin
                    err_nxt = 1'b1;
                    sh0_nxt = '0;
                    sh1_nxt = '0;
                    sh2_nxt = '0;
                end
            end
            advance = sync || (state == LOCKED);
        end

        // Sampling happens on the last hold cycle of a slot. Slot 3 is not
        // shadowed: it goes straight to O3 so the whole frame lands at once.
        if (advance) begin
            if (hold_eff == HOLD_LAST) begin
                hold_nxt = '0;
                s_nxt    = slot_eff + 2'd1;
                case (slot_eff)
                    2'd0: sh0_nxt = I0;
                    2'd1: sh1_nxt = I0;
                    2'd2: sh2_nxt = I0;
                    default: begin
                        o0_nxt    = sh0;
                        o1_nxt    = sh1;
                        o2_nxt    = sh2;
                        o3_nxt    = I0;
                        valid_nxt = 1'b1;
                    end
                endcase
            end else begin
                hold_nxt = hold_eff + HW'(1);
                s_nxt    = slot_eff;
            end
        end
    end

endmodule

// File: tb/tb_demux1t4_tdm.sv
// tb_demux1t4_tdm
// Self-checking bench for demux1t4_tdm. Two instances share clock and
// stimulus: inst0 is WIDTH=1/SLOT_HOLD=1 (sees bit 0 of the stream) and
// inst1 is WIDTH=4/SLOT_HOLD=2. A reference model tracks each receiver as
// a cycle position within a frame (0..4*SLOT_HOLD-1) and is compared to
// the DUT outputs every cycle, alongside hand-computed frame values.

module tb_demux1t4_tdm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sync = 1'b0;
    logic [3:0] din = 4'h0;

    logic       a_o0, a_o1, a_o2, a_o3, a_v, a_e;
    logic [1:0] a_s;
    logic [3:0] b_o0, b_o1, b_o2, b_o3;
    logic       b_v, b_e;
    logic [1:0] b_s;

    int nchecks = 0;
    int npass = 0;

    always #5 clk = ~clk;

    demux1t4_tdm #(.WIDTH(1), .SLOT_HOLD(1)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .I0(din[0]),
        .O0(a_o0), .O1(a_o1), .O2(a_o2), .O3(a_o3),
        .S(a_s), .valid(a_v), .sync_err(a_e)
    );

    demux1t4_tdm #(.WIDTH(4), .SLOT_HOLD(2)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .I0(din),
        .O0(b_o0), .O1(b_o1), .O2(b_o2), .O3(b_o3),
        .S(b_s), .valid(b_v), .sync_err(b_e)
    );

    // Reference model state, one entry per instance.
    int         m_sh[2] = '{1, 2};
    int         m_pos[2];
    bit         m_locked[2];
    bit         m_valid[2];
    bit         m_err[2];
    logic [3:0] m_shadow[2][4];
    logic [3:0] m_out[2][4];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pos[k] = 0;
            m_locked[k] = 0;
            m_valid[k] = 0;
            m_err[k] = 0;
            for (int j = 0; j < 4; j++) begin
                m_shadow[k][j] = 4'h0;
                m_out[k][j] = 4'h0;
            end
        end
    endtask

    task automatic model_step(input logic e, input logic s, input logic [3:0] dv);
        int p;
        int slot;
        logic [3:0] d;
        for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? {3'b000, dv[0]} : dv;
            m_valid[k] = 0;
            m_err[k] = 0;
            if (e) begin
                p = m_pos[k];
                if (s) begin
                    if (m_locked[k] && m_pos[k] != 0) begin
                        m_err[k] = 1;
                        for (int j = 0; j < 4; j++) m_shadow[k][j] = 4'h0;
                    end
                    m_locked[k] = 1;
                    p = 0;
                end
                if (m_locked[k]) begin
                    if (p % m_sh[k] == m_sh[k] - 1) begin
                        slot = p / m_sh[k];
                        if (slot == 3) begin
                            m_out[k][0] = m_shadow[k][0];
                            m_out[k][1] = m_shadow[k][1];
                            m_out[k][2] = m_shadow[k][2];
                            m_out[k][3] = d;
                            m_valid[k] = 1;
                        end else begin
                            m_shadow[k][slot] = d;
                        end
                    end
                    m_pos[k] = (p + 1) % (4 * m_sh[k]);
                end
            end
        end
    endtask

    function automatic logic [19:0] expv(input int k);
        return {m_out[k][0], m_out[k][1], m_out[k][2], m_out[k][3],
                2'(m_pos[k] / m_sh[k]), m_valid[k], m_err[k]};
    endfunction

    function automatic logic [19:0] obs(input int k);
        if (k == 0)
            return {3'b000, a_o0, 3'b000, a_o1, 3'b000, a_o2, 3'b000, a_o3, a_s, a_v, a_e};
        return {b_o0, b_o1, b_o2, b_o3, b_s, b_v, b_e};
    endfunction

    // Drives one cycle from a negedge and returns at the next negedge.
    task automatic drive(input logic e, input logic s, input logic [3:0] d);
        en = e;
        sync = s;
        din = d;
        @(posedge clk);
        model_step(e, s, d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            nchecks++;
            if (obs(k) !== 20'h0) $display("FAIL reset inst%0d: got %h want %h", k, obs(k), 20'h0);
            else npass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_frame();
        logic [3:0] d[4] = '{4'h0, 4'h1, 4'h1, 4'h0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, d[i]);
            for (int k = 0; k < 2; k++) begin
                nchecks++;
                if (obs(k) !== expv(k)) $display("FAIL first_frame inst%0d cyc%0d: got %h want %h", k, i, obs(k), expv(k));
                else npass++;
            end
        end
        nchecks++;
        if (obs(0) !== {4'h0, 4'h1, 4'h1, 4'h0, 2'd0, 1'b1, 1'b0})
            $display("FAIL first_frame_out: got %h want %h", obs(0), {4'h0, 4'h1, 4'h1, 4'h0, 2'd0, 1'b1, 1'b0});
        else npass++;
    endtask

    task automatic test_continuous();
        logic [3:0] d[8] = '{4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, d[i]);
            for (int k = 0; k < 2; k++) begin
                nchecks++;
                if (obs(k) !== expv(k)) $display("FAIL continuous inst%0d cyc%0d: got %h want %h", k, i, obs(k), expv(k));
                else npass++;
            end
            if (i == 3) begin
                nchecks++;
                if (obs(0) !== {4'h1, 4'h0, 4'h0, 4'h1, 2'd0, 1'b1, 1'b0})
                    $display("FAIL second_frame_out: got %h want %h", obs(0), {4'h1, 4'h0, 4'h0, 4'h1, 2'd0, 1'b1, 1'b0});
                else npass++;
            end
        end
        nchecks++;
        if (obs(0) !== {4'h1, 4'h1, 4'h1, 4'h1, 2'd0, 1'b1, 1'b0})
            $display("FAIL freerun_frame_out: got %h want %h", obs(0), {4'h1, 4'h1, 4'h1, 4'h1, 2'd0, 1'b1, 1'b0});
        else npass++;
    endtask

    task automatic test_slot_hold2();
        logic [3:0] d[4] = '{4'hA, 4'h5, 4'hC, 4'h3};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, d[i / 2]);
            for (int k = 0; k < 2; k++) begin
                nchecks++;
                if (obs(k) !== expv(k)) $display("FAIL slot_hold2 inst%0d cyc%0d: got %h want %h", k, i, obs(k), expv(k));
                else npass++;
            end
        end
        nchecks++;
        if (obs(1) !== {4'hA, 4'h5, 4'hC, 4'h3, 2'd0, 1'b1, 1'b0})
            $display("FAIL slot_hold2_out: got %h want %h", obs(1), {4'hA, 4'h5, 4'hC, 4'h3, 2'd0, 1'b1, 1'b0});
        else npass++;
    endtask

    task automatic test_misaligned();
        logic [3:0] d[6] = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1};
        logic       s[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, s[i], d[i]);
            for (int k = 0; k < 2; k++) begin
                nchecks++;
                if (obs(k) !== expv(k)) $display("FAIL misaligned inst%0d cyc%0d: got %h want %h", k, i, obs(k), expv(k));
                else npass++;
            end
            if (i == 2) begin
                nchecks++;
                if (a_e !== 1'b1 || a_v !== 1'b0) $display("FAIL sync_err_pulse: got err=%b valid=%b want err=1 valid=0", a_e, a_v);
                else npass++;
            end
        end
        nchecks++;
        if (obs(0) !== {4'h0, 4'h0, 4'h1, 4'h1, 2'd0, 1'b1, 1'b0})
            $display("FAIL resync_frame_out: got %h want %h", obs(0), {4'h0, 4'h0, 4'h1, 4'h1, 2'd0, 1'b1, 1'b0});
        else npass++;
    endtask

    task automatic test_enable_freeze();
        logic [3:0] r;
        drive(1'b1, 1'b1, 4'h1);
        drive(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            r = 4'($urandom);
            drive(1'b0, r[3], r);
            for (int k = 0; k < 2; k++) begin
                nchecks++;
                if (obs(k) !== expv(k)) $display("FAIL freeze inst%0d cyc%0d: got %h want %h", k, i, obs(k), expv(k));
                else npass++;
            end
            nchecks++;
            if (a_s !== 2'd2 || a_v !== 1'b0) $display("FAIL freeze_slot: got S=%0d valid=%b want S=2 valid=0", a_s, a_v);
            else npass++;
        end
        drive(1'b1, 1'b0, 4'h1);
        drive(1'b1, 1'b0, 4'h1);
        for (int k = 0; k < 2; k++) begin
            nchecks++;
            if (obs(k) !== expv(k)) $display("FAIL resume inst%0d: got %h want %h", k, obs(k), expv(k));
            else npass++;
        end
        nchecks++;
        if (obs(0) !== {4'h1, 4'h0, 4'h1, 4'h1, 2'd0, 1'b1, 1'b0})
            $display("FAIL resume_frame_out: got %h want %h", obs(0), {4'h1, 4'h0, 4'h1, 4'h1, 2'd0, 1'b1, 1'b0});
        else npass++;
    endtask

    task automatic test_random();
        logic e, s;
        logic [3:0] d;
        for (int i = 0; i < 400; i++) begin
            e = ($urandom % 8) != 0;
            s = ($urandom % 12) == 0;
            d = 4'($urandom);
            drive(e, s, d);
            for (int k = 0; k < 2; k++) begin
                nchecks++;
                if (obs(k) !== expv(k)) $display("FAIL random inst%0d cyc%0d: got %h want %h", k, i, obs(k), expv(k));
                else npass++;
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 4'hF);
        drive(1'b1, 1'b0, 4'hF);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            nchecks++;
            if (obs(k) !== 20'h0) $display("FAIL async_reset inst%0d: got %h want %h", k, obs(k), 20'h0);
            else npass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 4'($urandom));
            for (int k = 0; k < 2; k++) begin
                nchecks++;
                if (obs(k) !== expv(k)) $display("FAIL post_reset inst%0d cyc%0d: got %h want %h", k, i, obs(k), expv(k));
                else npass++;
            end
            nchecks++;
            if (a_v !== 1'b0 || a_s !== 2'd0 || b_v !== 1'b0 || b_s !== 2'd0)
                $display("FAIL unlocked_idle cyc%0d: got S=%0d/%0d valid=%b/%b want S=0 valid=0", i, a_s, b_s, a_v, b_v);
            else npass++;
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_continuous();
        test_slot_hold2();
        test_misaligned();
        test_enable_freeze();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule

// File: doc/demux1t4_tdm.md
Name: demux1t4_tdm

Overview:
- Receive-side counterpart of the 4:1 mux. Takes a time-division-multiplexed stream on a single input, where the upstream transmitter steps its select through slots 0..3.
- Recovers the four lanes into registered outputs O0..O3. Frame alignment comes from a sync marker.
- A one-cycle valid pulse is produced per complete frame.
- Sits at the receive end of the serial link; delivers lane data to downstream logic.

Parameters:
- WIDTH, 1, bit width of the input stream and of each output lane.
- SLOT_HOLD, 1, clock cycles per slot (>=1). Sampling happens on the last cycle of each slot.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance enable. 0 freezes all counters and suppresses sampling.
- sync  input  1  frame marker. High marks the current cycle as slot 0, hold cycle 0.
- I0  input  WIDTH  TDM data stream.
- O0  output  WIDTH  recovered lane 0.
- O1  output  WIDTH  recovered lane 1.
- O2  output  WIDTH  recovered lane 2.
- O3  output  WIDTH  recovered lane 3.
- S  output  2  slot currently being received (binary 0..3).
- valid  output  1  one-cycle pulse; O0..O3 hold a new complete frame.
- sync_err  output  1  one-cycle pulse; sync arrived at a non-frame boundary.

Behaviour:
- Reset (async, rst_n=0):
  - O0..O3=0, S=0, valid=0, sync_err=0.
  - Hold counter=0, shadow regs=0, locked=0.
  - Reset mid-frame discards the partial frame.
- Unlocked (locked=0):
  - No sampling; S stays 0; valid never asserts.
  - The first sync with en=1 sets locked=1, and that cycle counts as slot 0 / hold 0.
- Position tracking (locked, en=1, sync=0):
  - hold counts 0..SLOT_HOLD-1.
  - At hold==SLOT_HOLD-1: sample I0 into shadow[S], set hold=0, S=S+1 (wraps 3->0).
  - Otherwise hold=hold+1.
- sync handling (en=1):
  - The effective position for the cycle is forced to S=0, hold=0. The sampling rule then applies normally, so with SLOT_HOLD=1, slot 0 is sampled in the sync cycle.
  - If locked and the tracked position was not S=0/hold=0, sync_err=1 next cycle, shadow contents are discarded, and no valid is produced for the broken frame.
  - sync at the correct boundary is silent.
- Frame completion:
  - On the edge that samples slot 3, O0..O2 load shadow[0..2], O3 loads I0 directly, and valid=1.
  - Outputs update together, never partially.
  - Latency: O3 is visible 1 cycle after its sample cycle. O0 is visible 3*SLOT_HOLD+1 cycles after its sample.
  - valid=0 in all other cycles. O0..O3 hold their values between frames.
- en=0:
  - S, hold, shadows and outputs freeze; valid=0, sync_err=0.
  - sync is ignored.
  - On re-enable, reception resumes at the frozen position.
- Simultaneous sync and slot-3 sample: sync wins. The position becomes slot 0 and no frame completes.
- S output always reflects the slot to be received in the current cycle, and is registered.

Test Plan:
- Reset then sync (WIDTH=1, SLOT_HOLD=1): I0=0,1,1,0 over 4 cycles, sync with the first -> cycle after 4th: O0..O3=0,1,1,0, valid=1 for exactly 1 cycle; S sequence 0,1,2,3,0.
- Continuous frames: next frame I0=1,0,0,1 with sync at boundary -> O=1,0,0,1, valid once, sync_err stays 0; no sync for a 3rd frame 1,1,1,1 -> still O=1,1,1,1 (free-running wrap).
- SLOT_HOLD=2, WIDTH=4: I0 held 4'hA,4'h5,4'hC,4'h3 for 2 cycles each -> O0..O3=A,5,C,3, valid at cycle 9 after sync; S changes every 2 cycles.
- Misaligned sync: sync again at slot 2 -> sync_err=1 one cycle, no valid for that frame, next full frame from new sync with 0,0,1,1 -> O=0,0,1,1.
- en=0 for 3 cycles after slot 1 sampled, I0 toggling -> S stays 2, outputs unchanged; after re-enable remaining slots complete -> valid once with pre-freeze slot 0/1 data intact.
- Async reset asserted mid-slot 2 -> all outputs 0 immediately; no sync afterwards and I0 toggling 20 cycles -> valid never asserts, S=0.
